reset_sequencer: RTL and testbench

Parametrised reset generator for the avionics FPGA. Debounces the external board reset, accepts software and (optionally) watchdog reset requests, and drives `NUM_CH` active-high reset outputs that assert together and release in a staggered sequence. It sits at the top level between the board reset pin and the per-subsystem logic (sensor interfaces, telemetry, radio) and signals when the whole sequence has completed.

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/reset_debounce.sv | 37 +++
 rtl/reset_sequencer.sv | 140 ++++++++++++++
 tb/tb_reset_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared state encodings, reset-cause codes and a counter-width helper for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_EXT = 2'd1,
    CAUSE_SW  = 2'd2,
    CAUSE_WDT = 2'd3
  } cause_t;

  // Bits needed to hold 0..max_count; never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/reset_debounce.sv
// Board reset pin conditioning: 2-flop synchroniser followed by a saturating low-sample counter.
module reset_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ext_reset_n,
  output logic ext_rst_db
);

  localparam int W = cnt_width(DEBOUNCE_CYCLES);

  logic         r_sync1;
  logic         r_sync2;
  logic [W-1:0] r_low_cnt;

  // Synchroniser resets to the pin's idle (high) level so a block reset never looks like a board reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_low_cnt <= '0;
    end else begin
      r_sync1 <= i_ext_reset_n;
      r_sync2 <= r_sync1;
      if (r_sync2)
        r_low_cnt <= '0;
      else if (r_low_cnt != W'(DEBOUNCE_CYCLES))
        r_low_cnt <= r_low_cnt + 1'b1;
    end
  end

  assign ext_rst_db = (r_low_cnt == W'(DEBOUNCE_CYCLES));

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-channel reset generator with external, software and optional watchdog triggers.
// Watchdog logic is built only when RESET_SEQ_WDT_EN is defined.
//
// state   | meaning
// ASSERT  | all channels high, pulse counter runs once no trigger is active
// RELEASE | channels drop one by one every STAGGER_CYCLES, bit 0 first
// RUN     | all channels low, RESET_DONE high, watchdog armed
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int PULSE_CYCLES    = 48,
  parameter int STAGGER_CYCLES  = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WDT_CYCLES      = 48000000
) (
  input  logic              CLK_48MHZ,
  input  logic              RESET,
  input  logic              EXT_RESET_N,
  input  logic              SW_RESET_REQ,
  input  logic              WDT_KICK,
  output logic [NUM_CH-1:0] RESET_OUT,
  output logic              RESET_DONE,
  output logic [1:0]        RESET_CAUSE
);

  localparam int REL_MAX = (NUM_CH - 1) * STAGGER_CYCLES;
  localparam int PW      = cnt_width(PULSE_CYCLES - 1);
  localparam int RW      = cnt_width(REL_MAX);

  state_t            r_state;
  logic [PW-1:0]     r_pulse_cnt;
  logic [RW-1:0]     r_rel_cnt;
  logic [NUM_CH-1:0] r_out;
  logic              r_done;
  cause_t            r_cause;

  logic              w_ext_db;
  logic              w_wdt_fire;
  logic              w_trig;
  cause_t            w_cause;
  logic [RW-1:0]     w_rel_next;
  logic [NUM_CH-1:0] w_rel_mask;

  reset_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .i_clk         (CLK_48MHZ),
    .i_reset       (RESET),
    .i_ext_reset_n (EXT_RESET_N),
    .ext_rst_db    (w_ext_db)
  );

`ifdef RESET_SEQ_WDT_EN
  localparam int WW = cnt_width(WDT_CYCLES - 1);
  logic [WW-1:0] r_wdt_cnt;

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET || r_state != RUN || WDT_KICK || w_trig)
      r_wdt_cnt <= '0;
    else if (r_wdt_cnt != WW'(WDT_CYCLES - 1))
      r_wdt_cnt <= r_wdt_cnt + 1'b1;
  end

  assign w_wdt_fire = (r_state == RUN) && !WDT_KICK && (r_wdt_cnt == WW'(WDT_CYCLES - 1));
`else
  logic w_unused_wdt;
  assign w_unused_wdt = WDT_KICK ^ (WDT_CYCLES == 0);
  assign w_wdt_fire   = 1'b0;
`endif

  assign w_trig = w_ext_db | SW_RESET_REQ | w_wdt_fire;

  always_comb begin
    w_cause = CAUSE_SW;
    if (w_ext_db)        w_cause = CAUSE_EXT;
    else if (w_wdt_fire) w_cause = CAUSE_WDT;
  end

  // Channel mask for the release count the FSM is about to enter; entering RELEASE means count 0.
  assign w_rel_next = (r_state == RELEASE) ? r_rel_cnt + 1'b1 : '0;

  always_comb begin
    w_rel_mask = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_rel_mask[i] = (int'(w_rel_next) < i * STAGGER_CYCLES);
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      r_state     <= ASSERT;
      r_pulse_cnt <= '0;
      r_rel_cnt   <= '0;
      r_out       <= '1;
      r_done      <= 1'b0;
      r_cause     <= CAUSE_POR;
    end else if (w_trig) begin
      r_state     <= ASSERT;
      r_pulse_cnt <= '0;
      r_rel_cnt   <= '0;
      r_out       <= '1;
      r_done      <= 1'b0;
      r_cause     <= w_cause;
    end else begin
      case (r_state)
        ASSERT: begin
          if (r_pulse_cnt == PW'(PULSE_CYCLES - 1)) begin
            r_state   <= RELEASE;
            r_rel_cnt <= '0;
            r_out     <= w_rel_mask;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (r_rel_cnt == RW'(REL_MAX)) begin
            r_state <= RUN;
            r_out   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_rel_cnt <= w_rel_next;
            r_out     <= w_rel_mask;
          end
        end
        RUN: begin
          r_out  <= '0;
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ASSERT;
          r_out   <= '1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign RESET_OUT   = r_out;
  assign RESET_DONE  = r_done;
  assign RESET_CAUSE = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random triggers against a timeline model.
module tb_reset_sequencer;

  localparam int NCH   = 3;
  localparam int PULSE = 16;
  localparam int STAG  = 4;
  localparam int DEB   = 8;
  localparam int WDTC  = 100;
  localparam int MAXC  = 16384;
`ifdef RESET_SEQ_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           ext_n = 1'b1;
  logic           sw    = 1'b0;
  logic           kick  = 1'b0;
  logic [NCH-1:0] rst_out;
  logic           done;
  logic [1:0]     cause;

  reset_sequencer #(
    .NUM_CH(NCH), .PULSE_CYCLES(PULSE), .STAGGER_CYCLES(STAG),
    .DEBOUNCE_CYCLES(DEB), .WDT_CYCLES(WDTC)
  ) dut (
    .CLK_48MHZ(clk), .RESET(rst), .EXT_RESET_N(ext_n), .SW_RESET_REQ(sw),
    .WDT_KICK(kick), .RESET_OUT(rst_out), .RESET_DONE(done), .RESET_CAUSE(cause)
  );

  always #10 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc;
  int         last_trig;
  int         wdt_base;
  bit         prev_done;
  logic [1:0] cause_m;
  bit         pin_hist [MAXC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model: everything follows from the cycle count since the last trigger.
  function automatic int k_now();
    return cyc - last_trig - 1;
  endfunction

  function automatic logic [NCH-1:0] exp_out();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (k_now() < PULSE + i * STAG);
    return v;
  endfunction

  function automatic bit exp_done();
    return k_now() > PULSE + (NCH - 1) * STAG;
  endfunction

  // Debounced level in cycle c: pin low for DEB consecutive cycles ending 3 cycles earlier.
  function automatic bit db_at(input int c);
    if (c < DEB + 2) return 1'b0;
    for (int j = c - DEB - 2; j <= c - 3; j++)
      if (pin_hist[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit i_sw, input bit i_pin, input bit i_kick);
    bit d, w, dn;
    dn = exp_done();
    check("reset_out", rst_out, exp_out());
    check("reset_done", done, dn);
    check("reset_cause", cause, cause_m);
    if (dn && !prev_done) wdt_base = cyc;
    prev_done = dn;
    if (cyc < MAXC) pin_hist[cyc] = i_pin;
    d = db_at(cyc);
    w = WDT_EN && dn && !i_kick && (cyc - wdt_base == WDTC - 1);
    sw = i_sw; ext_n = i_pin; kick = i_kick;
    if (d || w || i_sw) begin
      last_trig = cyc;
      cause_m   = d ? 2'd1 : (w ? 2'd3 : 2'd2);
    end else if (i_kick && dn) begin
      wdt_base = cyc + 1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, want finish before 5ms");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, p, r, lows, burst;
    bit found;
    cyc = 0; last_trig = -1; wdt_base = 0; prev_done = 1'b0; cause_m = 2'd0;

    repeat (3) @(posedge clk);
    #1;
    check("por_out", rst_out, 3'b111);
    check("por_done", done, 1'b0);
    check("por_cause", cause, 2'd0);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      if (i == 15) check("stair_15", rst_out, 3'b111);
      if (i == 16) check("stair_16", rst_out, 3'b110);
      if (i == 20) check("stair_20", rst_out, 3'b100);
      if (i == 24) check("stair_24", rst_out, 3'b000);
      if (i == 25) check("done_25", done, 1'b1);
      step(1'b0, 1'b1, 1'b0);
    end

    n0 = cyc;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      if (i == 1)  check("sw_assert", rst_out, 3'b111);
      if (i == 17) check("sw_stair", rst_out, 3'b110);
      if (i == 26) check("sw_done", done, 1'b1);
      step(1'b0, 1'b1, 1'b0);
    end
    check("sw_cause", cause, 2'd2);
    check("sw_start", n0 + 31, cyc);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    check("short_low_ignored", done, 1'b1);

    p = cyc;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) check("ext_pre", rst_out, 3'b000);
      if (i == 11) check("ext_assert", rst_out, 3'b111);
      if (i == 58) check("ext_hold", rst_out, 3'b111);
      if (i == 59) check("ext_release", rst_out, 3'b110);
      step(1'b0, (i >= 40), 1'b0);
    end
    check("ext_cause", cause, 2'd1);
    check("ext_span", p + 100, cyc);

    step(1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (exp_out() == 3'b100) found = 1'b1;
      else step(1'b0, 1'b1, 1'b0);
    end
    check("find_100", found, 1'b1);
    check("mid_release_state", rst_out, 3'b100);
    step(1'b1, 1'b1, 1'b0);
    check("mid_release_reassert", rst_out, 3'b111);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (db_at(cyc)) found = 1'b1;
      else step(1'b0, 1'b0, 1'b0);
    end
    check("db_reach", found, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("cause_ext_over_sw", cause, 2'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);

    burst = 0;
    for (int i = 0; i < 1500; i++) begin
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(1, 30);
      step(($urandom_range(0, 99) == 0), (burst == 0), ($urandom_range(0, 39) == 0));
      if (burst > 0) burst--;
    end

`ifdef RESET_SEQ_WDT_EN
    step(1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (exp_done()) found = 1'b1;
      else step(1'b0, 1'b1, 1'b0);
    end
    check("wdt_reach_run", found, 1'b1);
    r = cyc;
    for (int i = 0; i < 100; i++) begin
      if (i == 99) check("wdt_pre_fire", rst_out, 3'b000);
      step(1'b0, 1'b1, 1'b0);
    end
    check("wdt_fire_out", rst_out, 3'b111);
    check("wdt_cause", cause, 2'd3);
    check("wdt_fire_time", r + 100, cyc);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (exp_done()) found = 1'b1;
      else step(1'b0, 1'b1, 1'b0);
    end
    check("wdt_rerun", found, 1'b1);
    lows = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!done) lows++;
      step(1'b0, 1'b1, (i % 50 == 0));
    end
    check("wdt_kicked_no_reset", lows, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
